// File: rtl/exec_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | exec_pkg                                                              |
// | Shared types for the execute-stage iterative multiply/divide unit.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package exec_pkg;

    localparam int MD_WIDTH = 64;
    localparam int CNT_W    = $clog2(MD_WIDTH);

    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_UMULH = 2'b01,
        MD_UDIV  = 2'b10,
        MD_SDIV  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } muldiv_state_t;

endpackage
`default_nettype wire

// File: rtl/exec_muldiv_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | exec_muldiv_seq_if                                                    |
// | Request/response bundle between the execute stage and the mul/div.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface exec_muldiv_seq_if #(
    parameter int WIDTH = 64
);
    logic             start_E;
    logic [1:0]       op_E;
    logic [WIDTH-1:0] opA_E;
    logic [WIDTH-1:0] opB_E;
    logic             flush_E;
    logic             stall_E;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start_E, op_E, opA_E, opB_E, flush_E,
        input  stall_E, busy, done, result
    );

    modport slave (
        input  start_E, op_E, opA_E, opB_E, flush_E,
        output stall_E, busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | muldiv_step                                                           |
// | One radix-2 iteration: shift-add multiply or restoring-divide step.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module muldiv_step #(
    parameter int WIDTH = 64
) (
    input  wire              i_is_div,
    input  wire  [WIDTH-1:0] i_hi,
    input  wire  [WIDTH-1:0] i_lo,
    input  wire  [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    always_comb begin
        // Multiply keeps the add carry in bit WIDTH so it shifts into acc_hi.
        w_sum    = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
        w_rem_sh = {i_hi, i_lo[WIDTH-1]};
        w_ge     = (w_rem_sh >= {1'b0, i_b});
        w_diff   = w_rem_sh[WIDTH-1:0] - i_b;

        if (i_is_div) begin
            o_hi = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], w_ge};
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/exec_muldiv_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | exec_muldiv_seq                                                       |
// | Iterative MUL/UMULH/UDIV/SDIV sequencer that stalls the pipeline.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module exec_muldiv_seq
    import exec_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input wire               clk,
    input wire               reset,
    exec_muldiv_seq_if.slave bus
);

    localparam int              CW       = ($clog2(WIDTH) > CNT_W) ? $clog2(WIDTH) : CNT_W;
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q, op_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             neg_q, neg_d;

    muldiv_op_t       op_in;
    logic             in_div;
    logic             in_sdiv;
    logic             q_div;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign op_in   = muldiv_op_t'(bus.op_E);
    assign in_div  = (op_in == MD_UDIV) || (op_in == MD_SDIV);
    assign in_sdiv = (op_in == MD_SDIV);
    assign q_div   = (op_q == MD_UDIV) || (op_q == MD_SDIV);
    assign mag_a   = (in_sdiv && bus.opA_E[WIDTH-1]) ? (~bus.opA_E + 1'b1) : bus.opA_E;
    assign mag_b   = (in_sdiv && bus.opB_E[WIDTH-1]) ? (~bus.opB_E + 1'b1) : bus.opB_E;

    // acc_hi/acc_lo double as rem/quo for divides.
    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_is_div (q_div),
        .i_hi     (hi_q),
        .i_lo     (lo_q),
        .i_b      (b_q),
        .o_hi     (step_hi),
        .o_lo     (step_lo)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        neg_d    = neg_q;
        result_d = result_q;

        if (bus.flush_E) begin
            state_d = MD_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (bus.start_E) begin
                        op_d    = op_in;
                        count_d = '0;
                        hi_d    = '0;
                        neg_d   = in_sdiv & (bus.opA_E[WIDTH-1] ^ bus.opB_E[WIDTH-1]);
                        if (in_div) begin
                            lo_d = mag_a;
                            b_d  = mag_b;
                        end else begin
                            lo_d = bus.opB_E;
                            b_d  = bus.opA_E;
                        end
                        if (in_div && (bus.opB_E == '0)) begin
                            result_d = '0;
                            state_d  = MD_DONE;
                        end else begin
                            state_d  = MD_RUN;
                        end
                    end
                end
                MD_RUN: begin
                    hi_d    = step_hi;
                    lo_d    = step_lo;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST_CNT) begin
                        count_d = '0;
                        state_d = MD_FIX;
                    end
                end
                MD_FIX: begin
                    case (op_q)
                        MD_MUL:   result_d = lo_q;
                        MD_UMULH: result_d = hi_q;
                        MD_UDIV:  result_d = lo_q;
                        MD_SDIV:  result_d = neg_q ? (~lo_q + 1'b1) : lo_q;
                        default:  result_d = lo_q;
                    endcase
                    state_d = MD_DONE;
                end
                MD_DONE: state_d = MD_IDLE;
                default: state_d = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            op_q     <= MD_MUL;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign bus.busy    = (state_q != MD_IDLE);
    assign bus.done    = (state_q == MD_DONE) & ~bus.flush_E;
    assign bus.result  = result_q;
    assign bus.stall_E = ~reset & ~bus.flush_E &
                         (((state_q == MD_IDLE) & bus.start_E) |
                          (state_q == MD_RUN) | (state_q == MD_FIX));

endmodule
`default_nettype wire

// File: tb/tb_exec_muldiv_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_exec_muldiv_seq                                                    |
// | Directed bench for the iterative multiply/divide sequencer.          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_exec_muldiv_seq;
    import exec_pkg::*;

    localparam int W   = 64;
    localparam int LAT = W + 2;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] last_result;

    exec_muldiv_seq_if #(.WIDTH(W)) bus ();

    exec_muldiv_seq #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered on a falling edge; launches one op and follows it to completion.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res, input int exp_lat,
                          input bit hold_start);
        int k;
        bit stall_ok;
        bit seen;
        bus.op_E    = op;
        bus.opA_E   = a;
        bus.opB_E   = b;
        bus.start_E = 1'b1;
        #1 stall_ok = (bus.stall_E === 1'b1);
        @(negedge clk);
        if (!hold_start) bus.start_E = 1'b0;
        k = 1;
        seen = 1'b0;
        while (k < 200) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.stall_E !== 1'b1) stall_ok = 1'b0;
            if (hold_start) begin
                bus.op_E  = 2'b00;
                bus.opA_E = a + 64'(k);
            end
            @(negedge clk);
            k++;
        end
        bus.start_E = 1'b0;
        if (bus.stall_E !== 1'b0) stall_ok = 1'b0;
        check({tag, " done seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(k), 64'(exp_lat));
        check({tag, " stall"}, 64'(stall_ok), 64'd1);
        check({tag, " result"}, bus.result, exp_res);
        @(negedge clk);
        check({tag, " done width"}, 64'({bus.done, bus.busy}), 64'd0);
        last_result = exp_res;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int dones;
        reset       = 1'b1;
        bus.start_E = 1'b0;
        bus.op_E    = 2'b00;
        bus.opA_E   = '0;
        bus.opB_E   = '0;
        bus.flush_E = 1'b0;
        last_result = '0;

        @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset result", bus.result, 64'd0);
        bus.start_E = 1'b1;
        #1 check("reset stall", 64'(bus.stall_E), 64'd0);
        @(negedge clk);
        bus.start_E = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        run_op("mul 7x6", MD_MUL, 64'd7, 64'd6, 64'd42, LAT, 1'b0);
        run_op("umulh ff*2", MD_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, LAT, 1'b0);
        run_op("mul ff*2", MD_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, LAT, 1'b0);
        run_op("mul wide lo", MD_MUL, 64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001, LAT, 1'b0);
        run_op("umulh wide", MD_UMULH, 64'h1_0000_0001, 64'h1_0000_0001, 64'd1, LAT, 1'b0);
        run_op("udiv 100/7", MD_UDIV, 64'd100, 64'd7, 64'd14, LAT, 1'b0);
        run_op("sdiv -100/7", MD_SDIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, LAT, 1'b0);
        run_op("sdiv 100/-7", MD_SDIV, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, LAT, 1'b0);
        run_op("sdiv -100/-7", MD_SDIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, LAT, 1'b0);
        run_op("sdiv min/-1", MD_SDIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, LAT, 1'b0);
        run_op("udiv 5/0", MD_UDIV, 64'd5, 64'd0, 64'd0, 1, 1'b0);
        run_op("udiv 100/7 again", MD_UDIV, 64'd100, 64'd7, 64'd14, LAT, 1'b0);
        run_op("sdiv -9/0", MD_SDIV, 64'hFFFF_FFFF_FFFF_FFF7, 64'd0, 64'd0, 1, 1'b0);
        run_op("udiv max/3", MD_UDIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, LAT, 1'b0);

        // Abort a multiply part-way through.
        bus.op_E    = MD_MUL;
        bus.opA_E   = 64'd3;
        bus.opB_E   = 64'd3;
        bus.start_E = 1'b1;
        @(negedge clk);
        bus.start_E = 1'b0;
        repeat (29) @(negedge clk);
        bus.flush_E = 1'b1;
        #1 check("flush stall drop", 64'(bus.stall_E), 64'd0);
        @(negedge clk);
        bus.flush_E = 1'b0;
        check("flush busy", 64'(bus.busy), 64'd0);
        check("flush result kept", bus.result, last_result);
        dones = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check("flush no done", 64'(dones), 64'd0);
        run_op("mul 2x5", MD_MUL, 64'd2, 64'd5, 64'd10, LAT, 1'b0);

        // Flush beats start in IDLE.
        bus.op_E    = MD_MUL;
        bus.start_E = 1'b1;
        bus.flush_E = 1'b1;
        #1 check("flush+start stall", 64'(bus.stall_E), 64'd0);
        @(negedge clk);
        bus.start_E = 1'b0;
        bus.flush_E = 1'b0;
        check("flush+start busy", 64'(bus.busy), 64'd0);

        // Asynchronous reset between clock edges mid-RUN.
        bus.op_E    = MD_MUL;
        bus.opA_E   = 64'd7;
        bus.opB_E   = 64'd6;
        bus.start_E = 1'b1;
        @(negedge clk);
        bus.start_E = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-reset busy", 64'(bus.busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset busy", 64'(bus.busy), 64'd0);
        check("async reset result", bus.result, 64'd0);
        check("async reset stall", 64'(bus.stall_E), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // start_E held high throughout with operands changing underneath.
        run_op("udiv held start", MD_UDIV, 64'd100, 64'd7, 64'd14, LAT, 1'b1);
        @(negedge clk);
        check("held start no relaunch", 64'(bus.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_muldiv_seq.md
Name: exec_muldiv_seq

Overview:
- Iterative multiply/divide sequencer that sits beside the execute-stage ALU.
- Accepts one MUL/UMULH/UDIV/SDIV operation, runs a radix-2 shift-add or shift-subtract loop over WIDTH cycles, and returns the result.
- While an operation is in flight it raises stall_E so the fetch/decode/execute pipeline registers hold.
- The result feeds the same writeback path as aluResult_E.

Parameters:
- WIDTH, 64, operand and result width in bits (even, ≥8).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start_E  in  1  request a new operation (sampled only in IDLE)
- op_E  in  2  00 MUL (low WIDTH bits), 01 UMULH (high WIDTH bits, unsigned), 10 UDIV, 11 SDIV
- opA_E  in  WIDTH  multiplicand / dividend (readData1_E)
- opB_E  in  WIDTH  multiplier / divisor (readData2_E)
- flush_E  in  1  synchronous abort (branch taken / exception)
- stall_E  out  1  hold upstream pipeline registers
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  final result, held stable until the next accepted start

Behaviour:
- Reset (asynchronous):
  - state=IDLE; count, accumulators and result = 0.
  - done=0, busy=0; stall_E=0 while reset is asserted.
- States: IDLE, RUN, FIX, DONE.
- IDLE + start_E=1 + flush_E=0:
  - Latch operands and op; count=0.
  - MUL/UMULH: acc_hi=0, acc_lo=opB. UDIV: rem=0, quo=opA.
  - SDIV: take magnitudes of opA and opB; record neg_q = opA[W-1] ^ opB[W-1].
  - If op is a divide and opB=0: go to DONE with result=0 (ARM semantics).
  - Otherwise go to RUN.
- RUN: one iteration per cycle; count increments.
  - MUL: if acc_lo[0], acc_hi += B (WIDTH+1-bit add); then shift {carry, acc_hi, acc_lo} right by 1.
  - DIV: rem = {rem, quo[W-1]}; quo <<= 1. If rem ≥ B: rem -= B, quo[0] = 1.
  - After WIDTH iterations (count = WIDTH-1 at the transition edge) go to FIX.
- FIX (1 cycle):
  - MUL → result = acc_lo. UMULH → result = acc_hi. UDIV → result = quo.
  - SDIV → result = neg_q ? -quo : quo.
  - SDIV of -2^(W-1) by -1 yields -2^(W-1) (wrap, no trap).
  - Go to DONE.
- DONE (1 cycle): done=1, then IDLE. start_E in DONE is ignored; the requester re-asserts start_E in IDLE.
- Latency:
  - start accepted at edge N → done high in the cycle after edge N+WIDTH+1 (66 cycles total for WIDTH=64).
  - Divide-by-zero: done high in the cycle after edge N.
- stall_E (combinational) = (IDLE & start_E & ~flush_E) | RUN | FIX. It is 0 in DONE, so the stage advances and consumes result.
- start_E in RUN/FIX/DONE is ignored; no queueing.
- flush_E in any state:
  - Next state IDLE, count=0; no done pulse.
  - result keeps its prior value; stall_E drops in the same cycle.
- flush_E and start_E together in IDLE: flush wins, operation not accepted.
- Reset mid-operation: immediate return to IDLE, result=0.
- All arithmetic is unsigned WIDTH-bit modulo except the SDIV sign fix. The MUL carry is kept in one extra bit.

Decomposition:
- Package exec_pkg:
  - muldiv_op_t enum {MD_MUL, MD_UMULH, MD_UDIV, MD_SDIV}.
  - muldiv_state_t enum {MD_IDLE, MD_RUN, MD_FIX, MD_DONE}.
  - Localparam CNT_W = $clog2(WIDTH).
- One natural sub-module, muldiv_step: a combinational single-iteration datapath (add/shift or compare/subtract/shift) selected by the op class. The FSM, counter and registers stay in exec_muldiv_seq.

Test Plan:
1. MUL 7 × 6, start one cycle → stall_E high until the DONE cycle; done pulse exactly 66 cycles after start; result = 42.
2. UMULH 0xFFFF_FFFF_FFFF_FFFF × 2 → result = 1. MUL with the same operands → result = 0xFFFF_FFFF_FFFF_FFFE.
3. UDIV 100 / 7 → result = 14. SDIV -100 / 7 → result = -14 (0xFFFF_FFFF_FFFF_FFF2). SDIV 0x8000_0000_0000_0000 / -1 → result = 0x8000_0000_0000_0000.
4. UDIV 5 / 0 → done after 1 cycle, result = 0, stall_E high only in the start cycle.
5. flush_E at iteration 30 of MUL 3×3 → IDLE the next cycle, no done, result unchanged (prior value). A new start with 2×5 then gives 10.
6. Asynchronous reset pulse mid-RUN (between clock edges) → busy=0, result=0 immediately. start_E held high during RUN/DONE → no second operation launched.
